// File: rtl/spi_slave_fsm.sv
// SPI slave transaction controller.
// Walks one frame (7-bit address + R/W bit, then 8 data bits) and drives the
// shift-register, address-latch, data-memory and MISO-buffer enables.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | chip select inactive, waiting for CS to fall
// RX_ADDR      | shifting in address + R/W bit, counting SCLK edges
// DECODE       | latch address, pick read or write path from rw_bit
// READ_LOAD    | parallel-load shift register from data memory
// READ_TX      | MISO driven, counting data edges out
// WRITE_RX     | counting data edges in
// WRITE_COMMIT | write shifted byte into data memory
// DONE         | frame complete, waiting for CS to rise
//
// CS rising in any non-IDLE state returns to IDLE on the next cycle and
// overrides any other transition, including a coincident SCLK edge.
module spi_slave_fsm #(
  parameter int framebits    = 8,
  parameter int counterwidth = 3   // 2**counterwidth must cover framebits
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_conditioned,
  input  logic       sclk_posedge,
  input  logic       rw_bit,
  output logic       sr_we,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_buff,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_RX_ADDR      = 3'd1;
  localparam logic [2:0] S_DECODE       = 3'd2;
  localparam logic [2:0] S_READ_LOAD    = 3'd3;
  localparam logic [2:0] S_READ_TX      = 3'd4;
  localparam logic [2:0] S_WRITE_RX     = 3'd5;
  localparam logic [2:0] S_WRITE_COMMIT = 3'd6;
  localparam logic [2:0] S_DONE         = 3'd7;

  localparam logic [counterwidth-1:0] CNT_LAST = counterwidth'(framebits - 1);
  localparam logic [counterwidth-1:0] CNT_ONE  = counterwidth'(1);

  logic [2:0]              state_q, state_d;
  logic [counterwidth-1:0] cnt_q, cnt_d;
  logic                    sr_we_q, addr_we_q, dm_we_q, miso_buff_q, busy_q, done_q;
  logic                    abort;
  logic                    cnt_term;

  // CS release anywhere outside IDLE aborts the frame.
  always_comb begin
    abort    = cs_conditioned && (state_q != S_IDLE);
    cnt_term = (cnt_q == CNT_LAST);
  end

  // Next-state and bit-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // An SCLK edge coinciding with CS fall belongs to no frame yet.
          if (!cs_conditioned) begin
            state_d = S_RX_ADDR;
            cnt_d   = '0;
          end
        end
        S_RX_ADDR: begin
          if (sclk_posedge) begin
            if (cnt_term) begin
              state_d = S_DECODE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_DECODE: begin
          state_d = rw_bit ? S_READ_LOAD : S_WRITE_RX;
        end
        S_READ_LOAD: begin
          state_d = S_READ_TX;
        end
        S_READ_TX: begin
          if (sclk_posedge) begin
            if (cnt_term) begin
              state_d = S_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_WRITE_RX: begin
          if (sclk_posedge) begin
            if (cnt_term) begin
              state_d = S_WRITE_COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        S_WRITE_COMMIT: begin
          state_d = S_DONE;
        end
        S_DONE: begin
          // Extra SCLK edges are ignored; only CS release (abort path) leaves.
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enables are decoded from the next state so each one is a flop that is
  // high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_we_q     <= 1'b0;
      addr_we_q   <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_buff_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sr_we_q     <= (state_d == S_READ_LOAD);
      addr_we_q   <= (state_d == S_DECODE);
      dm_we_q     <= (state_d == S_WRITE_COMMIT);
      miso_buff_q <= (state_d == S_READ_TX);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

  // Output mapping.
  always_comb begin
    sr_we     = sr_we_q;
    addr_we   = addr_we_q;
    dm_we     = dm_we_q;
    miso_buff = miso_buff_q;
    busy      = busy_q;
    done      = done_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_spi_slave_fsm.sv
// Testbench for spi_slave_fsm: directed frames from the test plan followed by
// randomized frames, checked every cycle against a frame-position model.
module tb_spi_slave_fsm;

  localparam int FB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs_conditioned;
  logic       sclk_posedge;
  logic       rw_bit;
  logic       sr_we, addr_we, dm_we, miso_buff, busy, done;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  // Model: frame described by how many SCLK edges were accepted and how many
  // cycles have passed since the latest accepted edge.
  bit m_active;
  int m_edges;
  int m_since;
  bit m_rw;
  int m_prev;

  always #5 clk = ~clk;

  spi_slave_fsm #(.framebits(FB), .counterwidth(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .cs_conditioned(cs_conditioned),
    .sclk_posedge  (sclk_posedge),
    .rw_bit        (rw_bit),
    .sr_we         (sr_we),
    .addr_we       (addr_we),
    .dm_we         (dm_we),
    .miso_buff     (miso_buff),
    .busy          (busy),
    .done          (done),
    .state         (state)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Expected state number from frame position.
  function automatic int exp_state();
    if (!m_active) return 0;
    if (m_edges < FB) return 1;
    if (m_edges == FB && m_since == 1) return 2;
    if (m_edges < 2 * FB) begin
      if (m_rw) return (m_edges == FB && m_since == 2) ? 3 : 4;
      return 5;
    end
    if (!m_rw && m_since == 1) return 6;
    return 7;
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_edges  = 0;
    m_since  = 0;
    m_rw     = 1'b0;
    m_prev   = 0;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_clock(input bit cs, input bit sclk, input bit rw);
    int cur;
    cur    = exp_state();
    m_prev = cur;
    if (!m_active) begin
      if (!cs) begin
        m_active = 1'b1;
        m_edges  = 0;
        m_since  = 0;
      end
    end else if (cs) begin
      m_active = 1'b0;
    end else begin
      if (cur == 2) m_rw = rw;
      if (sclk && (cur == 1 || cur == 4 || cur == 5)) begin
        m_edges++;
        m_since = 1;
      end else if (m_since < 1000) begin
        m_since++;
      end
    end
  endfunction

  task automatic check_outputs();
    int es;
    es = exp_state();
    chk_eq("state",     32'(state),     32'(es));
    chk_eq("busy",      32'(busy),      32'(es != 0));
    chk_eq("done",      32'(done),      32'(es == 7 && m_prev != 7));
    chk_eq("sr_we",     32'(sr_we),     32'(es == 3));
    chk_eq("addr_we",   32'(addr_we),   32'(es == 2));
    chk_eq("dm_we",     32'(dm_we),     32'(es == 6));
    chk_eq("miso_buff", 32'(miso_buff), 32'(es == 4));
  endtask

  // One clock: drive at negedge, model at posedge, check at next negedge.
  task automatic step(input bit cs, input bit sclk, input bit rw);
    cs_conditioned = cs;
    sclk_posedge   = sclk;
    rw_bit         = rw;
    @(posedge clk);
    model_clock(cs, sclk, rw);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic edges(input int n, input bit rw, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gmin, gmax)) step(1'b0, 1'b0, rw);
      step(1'b0, 1'b1, rw);
    end
  endtask

  task automatic frame(input int nedges, input bit rw, input int extra,
                       input bit abort_with_edge, input int gmin, input int gmax);
    step(1'b0, 1'($urandom_range(0, 1)), rw);
    edges(nedges, rw, gmin, gmax);
    for (int i = 0; i < extra; i++) begin
      repeat (2) step(1'b0, 1'b0, rw);
      step(1'b0, 1'b1, rw);
    end
    repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, rw);
    if (abort_with_edge) step(1'b1, 1'b1, rw);
    step(1'b1, 1'b0, rw);
    step(1'b1, 1'b0, rw);
  endtask

  initial begin
    model_reset();
    reset          = 1'b1;
    cs_conditioned = 1'b1;
    sclk_posedge   = 1'b0;
    rw_bit         = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) step(1'b1, 1'b0, 1'b0);

    // Write frame, read frame.
    frame(2 * FB, 1'b0, 0, 1'b0, 2, 3);
    frame(2 * FB, 1'b1, 0, 1'b0, 2, 3);

    // Abort mid-write after 12 edges, then a clean write.
    frame(12, 1'b0, 0, 1'b0, 2, 3);
    frame(2 * FB, 1'b0, 0, 1'b0, 2, 3);

    // CS rise coinciding with the sixth address edge, then a clean write.
    frame(5, 1'b0, 0, 1'b1, 2, 3);
    frame(2 * FB, 1'b0, 0, 1'b0, 2, 3);

    // Extra edges while in DONE.
    frame(2 * FB, 1'b1, 3, 1'b0, 2, 3);

    // Async reset in the middle of READ_TX, off the clock edge.
    step(1'b0, 1'b0, 1'b1);
    edges(FB + 3, 1'b1, 2, 3);
    #3;
    reset = 1'b1;
    #1;
    chk_eq("rst_state",   32'(state),     32'd0);
    chk_eq("rst_busy",    32'(busy),      32'd0);
    chk_eq("rst_miso",    32'(miso_buff), 32'd0);
    chk_eq("rst_enables", 32'({sr_we, addr_we, dm_we, done}), 32'd0);
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    edges(2 * FB, 1'b1, 2, 3);
    repeat (2) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Randomized frames, including tight edge spacing and aborts.
    for (int f = 0; f < 60; f++) begin
      int  n;
      bit  ab;
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 * FB - 1)) : 2 * FB;
      ab = (n < 2 * FB) && ($urandom_range(0, 1) == 1);
      frame(n, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), ab,
            int'($urandom_range(0, 2)), int'($urandom_range(2, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_fsm.md
Name: spi_slave_fsm

Overview:
- Transaction controller for the SPI slave datapath.
- Consumes the conditioned chip-select level and the one-cycle SCLK rising-edge pulse produced by the input conditioners.
- Sequences the shift register, address latch, data memory and MISO tri-state buffer through one frame: 7-bit address, R/W bit, then 8 data bits.
- Sits between the conditioners and the shift-register/memory datapath in the SPI top level.

Parameters:
- framebits, 8, number of SCLK rising edges per byte phase (address phase and data phase).
- counterwidth, 3, width of the internal bit counter; must satisfy 2^counterwidth >= framebits.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high reset.
- cs_conditioned  input  1  conditioned chip select, active low.
- sclk_posedge  input  1  one-cycle pulse on each conditioned SCLK rising edge.
- rw_bit  input  1  shift register parallel-out bit 0 (1 = read, 0 = write); sampled in DECODE only.
- sr_we  output  1  shift register parallel load from data memory.
- addr_we  output  1  address latch write enable.
- dm_we  output  1  data memory write enable.
- miso_buff  output  1  MISO tri-state enable.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on entry to DONE.
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset (asynchronous): state=IDLE, bit counter=0, all outputs 0.
- All outputs are Moore and registered: each asserts for exactly the cycle(s) the FSM is in the listed state.
- State encoding: IDLE=0, RX_ADDR=1, DECODE=2, READ_LOAD=3, READ_TX=4, WRITE_RX=5, WRITE_COMMIT=6, DONE=7.
- IDLE
  - cs_conditioned==0 -> RX_ADDR, counter<=0.
  - An sclk_posedge in the same cycle is ignored.
- RX_ADDR
  - Each sclk_posedge increments the counter.
  - sclk_posedge with counter==framebits-1 -> DECODE, counter<=0.
- DECODE (1 cycle)
  - addr_we=1.
  - Next state is READ_LOAD if rw_bit==1, else WRITE_RX.
- READ_LOAD (1 cycle): sr_we=1 -> READ_TX.
- READ_TX
  - miso_buff=1.
  - Counts sclk_posedge; on edge with counter==framebits-1 -> DONE, counter<=0.
- WRITE_RX
  - Counts sclk_posedge; on edge with counter==framebits-1 -> WRITE_COMMIT, counter<=0.
- WRITE_COMMIT (1 cycle): dm_we=1 -> DONE.
- DONE
  - done=1 on the entry cycle only.
  - Remains in DONE, ignoring further sclk_posedge, until cs_conditioned==1 -> IDLE.
- Abort
  - cs_conditioned==1 in any non-IDLE state -> IDLE next cycle, counter<=0.
  - Abort takes priority over every other transition and over a simultaneous sclk_posedge.
  - Abort from WRITE_RX: dm_we never asserts.
  - Abort from WRITE_COMMIT: the dm_we already asserted in that cycle stands.
- Edge timing
  - sclk_posedge arriving during DECODE, READ_LOAD or WRITE_COMMIT is not counted.
  - Conditioner latency guarantees at least 3 clk cycles between SCLK edges, so no edge is lost in normal operation.
- Counter
  - Counts only in RX_ADDR, READ_TX and WRITE_RX.
  - Never exceeds framebits-1; no wrap occurs because the FSM leaves the state on the terminal edge.
- Latency
  - Last address edge -> addr_we: 1 cycle.
  - Last write-data edge -> dm_we: 1 cycle.
  - Read: sr_we lands 2 cycles after the last address edge.

Test Plan:
- Write frame: CS low, 8 edges with rw_bit=0 in DECODE, then 8 edges, CS high -> addr_we pulses once, dm_we pulses once 1 cycle after edge 16, done pulses once, sr_we and miso_buff stay 0, state returns to 0.
- Read frame: CS low, 8 edges with rw_bit=1 -> addr_we at edge8+1, sr_we at edge8+2, miso_buff high until edge 16; dm_we never asserts; done pulses after edge 16.
- Abort mid-write: CS high after 12 edges -> IDLE next cycle; dm_we never asserts; a following full write frame completes normally with a single dm_we pulse.
- Simultaneous CS rise and sclk_posedge in RX_ADDR at counter=5 -> IDLE, counter=0, addr_we not asserted.
- Asynchronous reset asserted mid-READ_TX (not clock-aligned) -> all outputs 0 and state=0 immediately; after release, CS still low -> RX_ADDR with counter=0.
- Extra edges in DONE: 3 sclk_posedge pulses after edge 16 with CS low -> state stays 7, no enables assert, done pulses only once.
